// File: rtl/exe_stage_pkg.sv
// Shared ARM definitions: ALU command encodings and NZCV bit positions.
package exe_stage_pkg;

    localparam int EXE_CMD_W_DEF = 4;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_if.sv
// Decode-to-execute bus: instruction, operands, controls and EXE/MEM results.
interface exe_stage_if #(parameter int EXE_CMD_W = 4);
    logic                 valid_in;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 s_bit;
    logic [31:0]          val_rn;
    logic [31:0]          val2;
    logic [31:0]          val_rm_in;
    logic                 wb_en_in;
    logic                 mem_r_en_in;
    logic                 mem_w_en_in;
    logic [3:0]           dest_in;
    logic                 b_in;
    logic [31:0]          pc_in;
    logic [23:0]          signed_imm_24;

    logic [3:0]           status;
    logic                 branch_taken;
    logic [31:0]          branch_address;
    logic [31:0]          alu_result_out;
    logic [31:0]          val_rm_out;
    logic [3:0]           dest_out;
    logic                 wb_en_out;
    logic                 mem_r_en_out;
    logic                 mem_w_en_out;

    modport master (
        output valid_in, exe_cmd, s_bit, val_rn, val2, val_rm_in,
               wb_en_in, mem_r_en_in, mem_w_en_in, dest_in,
               b_in, pc_in, signed_imm_24,
        input  status, branch_taken, branch_address, alu_result_out,
               val_rm_out, dest_out, wb_en_out, mem_r_en_out, mem_w_en_out
    );

    modport slave (
        input  valid_in, exe_cmd, s_bit, val_rn, val2, val_rm_in,
               wb_en_in, mem_r_en_in, mem_w_en_in, dest_in,
               b_in, pc_in, signed_imm_24,
        output status, branch_taken, branch_address, alu_result_out,
               val_rm_out, dest_out, wb_en_out, mem_r_en_out, mem_w_en_out
    );
endinterface

// File: rtl/exe_stage_alu.sv
// Combinational ALU: result and next NZCV from operands, command and current flags.
module alu
    import exe_stage_pkg::*;
#(
    parameter int EXE_CMD_W = EXE_CMD_W_DEF
) (
    input  logic [31:0]          rn,
    input  logic [31:0]          val2,
    input  logic [EXE_CMD_W-1:0] cmd,
    input  logic [3:0]           flags_in,
    output logic [31:0]          result,
    output logic [3:0]           flags
);

    logic [32:0] sum;
    logic        cin;
    logic        defined;

    assign cin = flags_in[FLAG_C];

    // Operation decode; undefined codes give 0 and leave every flag alone.
    always_comb begin
        sum     = '0;
        result  = '0;
        defined = 1'b1;
        flags   = flags_in;
        case (cmd)
            CMD_MOV: result = val2;
            CMD_MVN: result = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum    = {1'b0, rn} + {1'b0, val2} + {32'b0, (cmd == CMD_ADC) & cin};
                result = sum[31:0];
                flags[FLAG_C] = sum[32];
                flags[FLAG_V] = (rn[31] == val2[31]) && (result[31] != rn[31]);
            end
            CMD_SUB, CMD_SBC: begin
                sum    = {1'b0, rn} - {1'b0, val2} - {32'b0, (cmd == CMD_SBC) & ~cin};
                result = sum[31:0];
                flags[FLAG_C] = ~sum[32];
                flags[FLAG_V] = (rn[31] != val2[31]) && (result[31] != rn[31]);
            end
            CMD_AND: result = rn & val2;
            CMD_ORR: result = rn | val2;
            CMD_EOR: result = rn ^ val2;
            default: defined = 1'b0;
        endcase
        if (defined) begin
            flags[FLAG_N] = result[31];
            flags[FLAG_Z] = (result == 32'd0);
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV status register, branch target and EXE/MEM register.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int EXE_CMD_W = EXE_CMD_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    exe_stage_if.slave bus
);

    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  status_q;
    logic [31:0] result_q;
    logic [31:0] val_rm_q;
    logic [3:0]  dest_q;
    logic        wb_en_q;
    logic        mem_r_en_q;
    logic        mem_w_en_q;

    alu #(.EXE_CMD_W(EXE_CMD_W)) u_alu (
        .rn       (bus.val_rn),
        .val2     (bus.val2),
        .cmd      (bus.exe_cmd),
        .flags_in (status_q),
        .result   (alu_result),
        .flags    (alu_flags)
    );

    // Status and EXE/MEM registers; freeze holds everything, invalid slots become bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= '0;
            result_q   <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
        end else if (!freeze) begin
            if (bus.s_bit && bus.valid_in) begin
                status_q <= alu_flags;
            end
            result_q   <= alu_result;
            val_rm_q   <= bus.val_rm_in;
            dest_q     <= bus.dest_in;
            wb_en_q    <= bus.wb_en_in & bus.valid_in;
            mem_r_en_q <= bus.mem_r_en_in & bus.valid_in;
            mem_w_en_q <= bus.mem_w_en_in & bus.valid_in;
        end
    end

    // Branch target is word-offset relative to PC+4 and simply wraps modulo 2^32.
    assign bus.branch_address = bus.pc_in + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};
    assign bus.branch_taken   = bus.b_in & bus.valid_in;

    assign bus.status         = status_q;
    assign bus.alu_result_out = result_q;
    assign bus.val_rm_out     = val_rm_q;
    assign bus.dest_out       = dest_q;
    assign bus.wb_en_out      = wb_en_q;
    assign bus.mem_r_en_out   = mem_r_en_q;
    assign bus.mem_w_en_out   = mem_w_en_q;

endmodule
